// File: rtl/fuzzifier_seq.sv
// fuzzifier_seq: time-multiplexed trapezoidal fuzzifier with a shared restoring divider.
// Optional macro FUZZ_ORDER_CHECK_EN enables the a<=b<=c<=d ordering check and sticky cfg_err.
`default_nettype none

module fuzzifier_seq #(
    parameter int W      = 8,
    parameter int N_SETS = 3,
    parameter int MU_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             x,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_set,
    input  logic [1:0]               cfg_pt,
    input  logic [W-1:0]             cfg_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_SETS*MU_W-1:0]   mu_flat,
    output logic                     cfg_err
);

    localparam int NW    = W + 1 + MU_W;
    localparam int SI_W  = (N_SETS > 1) ? $clog2(N_SETS) : 1;
    localparam int CYC_W = $clog2(MU_W + 1);
    localparam logic [MU_W-1:0] MU_FULL = {MU_W{1'b1}};

    typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, HOLD = 2'd2} state_t;

    state_t                state;
    logic signed [W-1:0]   bank [N_SETS][4];
    logic signed [W-1:0]   x_q;
    logic [SI_W-1:0]       set_idx;
    logic [CYC_W-1:0]      cyc;
    logic [W+1:0]          rem;
    logic [MU_W-1:0]       num_lo;
    logic [MU_W-1:0]       quo;
    logic [W:0]            den;
    logic                  force_full;
    logic                  force_zero;

    logic signed [W-1:0]   pa, pb, pc, pd;
    logic signed [W:0]     ex, ea, eb, ec, ed;
    logic                  sel_full, sel_zero;
    logic [W:0]            diff, den_c;
    logic [NW-1:0]         num;
    logic [W+1:0]          trial;
    logic                  qbit;
    logic [W+1:0]          rem_next;

`ifdef FUZZ_ORDER_CHECK_EN
    logic err_q;
    logic order_bad;
    assign order_bad = !((pa <= pb) && (pb <= pc) && (pc <= pd));
    assign cfg_err   = err_q;
`else
    assign cfg_err   = 1'b0;
`endif

    // Classification of the current set against the captured sample
    always_comb begin
        pa = bank[set_idx][0];
        pb = bank[set_idx][1];
        pc = bank[set_idx][2];
        pd = bank[set_idx][3];
        ex = {x_q[W-1], x_q};
        ea = {pa[W-1], pa};
        eb = {pb[W-1], pb};
        ec = {pc[W-1], pc};
        ed = {pd[W-1], pd};
        sel_full = 1'b0;
        sel_zero = 1'b0;
        diff     = '0;
        den_c    = {{W{1'b0}}, 1'b1};
        if (x_q >= pb && x_q <= pc) begin
            sel_full = 1'b1;
        end else if (x_q <= pa || x_q >= pd) begin
            sel_zero = 1'b1;
        end else if (x_q > pa && x_q < pb) begin
            diff  = ex - ea;
            den_c = eb - ea;
        end else begin
            diff  = ed - ex;
            den_c = ed - ec;
        end
        num = {diff, {MU_W{1'b0}}} - {{MU_W{1'b0}}, diff};
    end

    // One restoring-division step: bring down the next numerator bit
    always_comb begin
        trial    = {rem[W:0], num_lo[MU_W-1]};
        qbit     = (trial >= {1'b0, den});
        rem_next = qbit ? (trial - {1'b0, den}) : trial;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            mu_flat    <= '0;
            x_q        <= '0;
            set_idx    <= '0;
            cyc        <= '0;
            rem        <= '0;
            num_lo     <= '0;
            quo        <= '0;
            den        <= '0;
            force_full <= 1'b0;
            force_zero <= 1'b0;
            for (int s = 0; s < N_SETS; s++) begin
                for (int p = 0; p < 4; p++) begin
                    bank[s][p] <= '0;
                end
            end
`ifdef FUZZ_ORDER_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            if (cfg_we && state != EVAL && 32'(cfg_set) < N_SETS) begin
                bank[cfg_set[SI_W-1:0]][cfg_pt] <= cfg_data;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q      <= x;
                        set_idx  <= '0;
                        cyc      <= '0;
                        in_ready <= 1'b0;
                        state    <= EVAL;
                    end
                end
                EVAL: begin
                    if (cyc == '0) begin
                        rem        <= {1'b0, num[NW-1:MU_W]};
                        num_lo     <= num[MU_W-1:0];
                        den        <= den_c;
                        quo        <= '0;
                        force_full <= sel_full;
                        force_zero <= sel_zero;
`ifdef FUZZ_ORDER_CHECK_EN
                        if (order_bad) begin
                            force_full <= 1'b0;
                            force_zero <= 1'b1;
                            err_q      <= 1'b1;
                        end
`endif
                        cyc <= cyc + CYC_W'(1);
                    end else begin
                        rem    <= rem_next;
                        num_lo <= {num_lo[MU_W-2:0], 1'b0};
                        quo    <= {quo[MU_W-2:0], qbit};
                        if (cyc == CYC_W'(MU_W)) begin
                            mu_flat[set_idx*MU_W +: MU_W] <= force_full ? MU_FULL :
                                                             force_zero ? '0 :
                                                             {quo[MU_W-2:0], qbit};
                            cyc <= '0;
                            if (set_idx == SI_W'(N_SETS - 1)) begin
                                out_valid <= 1'b1;
                                state     <= HOLD;
                            end else begin
                                set_idx <= set_idx + SI_W'(1);
                            end
                        end else begin
                            cyc <= cyc + CYC_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fuzzifier_seq.sv
// tb_fuzzifier_seq: directed self-checking bench for fuzzifier_seq (default parameters).
`default_nettype none

module tb_fuzzifier_seq;

    localparam int W = 8, N_SETS = 3, MU_W = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [W-1:0]           x = '0;
    logic                   cfg_we = 1'b0;
    logic [2:0]             cfg_set = '0;
    logic [1:0]             cfg_pt = '0;
    logic [W-1:0]           cfg_data = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [N_SETS*MU_W-1:0] mu_flat;
    logic                   cfg_err;

    int errors = 0;
    int checks = 0;
    int lat;
    int bad;
    logic [47:0] held;
    logic exp_err;

    fuzzifier_seq #(.W(W), .N_SETS(N_SETS), .MU_W(MU_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .cfg_we(cfg_we), .cfg_set(cfg_set), .cfg_pt(cfg_pt), .cfg_data(cfg_data),
        .out_valid(out_valid), .out_ready(out_ready), .mu_flat(mu_flat), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input int s, input int p, input int d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_set = 3'(s); cfg_pt = 2'(p); cfg_data = W'(d);
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic start_sample(input int xv);
        @(negedge clk);
        in_valid = 1'b1; x = W'(xv);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // lat counts the accepting cycle as 1
    task automatic wait_result(output int l);
        l = 1;
        forever begin
            @(negedge clk);
            if (out_valid || l >= 300) break;
            l++;
        end
        if (!out_valid) check("ov_timeout", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic sample(input string tag, input int xv, input logic [47:0] exp_mu);
        start_sample(xv);
        wait_result(lat);
        check({tag, "_lat"}, 64'(lat), 64'd52);
        check({tag, "_mu"}, 64'(mu_flat), 64'(exp_mu));
    endtask

    initial begin
`ifdef FUZZ_ORDER_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mu", 64'(mu_flat), 64'd0);
        check("rst_cfg_err", {63'd0, cfg_err}, 64'd0);

        // All-zero bank: x=0 is full membership in every set
        sample("zero_bank", 0, 48'hFFFF_FFFF_FFFF);
        release_out();

        cfg_write(0, 0, -128); cfg_write(0, 1, -128); cfg_write(0, 2, -40); cfg_write(0, 3, -10);
        cfg_write(1, 0, -20);  cfg_write(1, 1, -5);   cfg_write(1, 2, 5);   cfg_write(1, 3, 20);
        cfg_write(2, 0, 10);   cfg_write(2, 1, 40);   cfg_write(2, 2, 127); cfg_write(2, 3, 127);

        sample("x0", 0, 48'h0000_FFFF_0000);
        release_out();
        sample("xm15", -15, 48'h0000_5555_2AAA);

        // Backpressure with a stray in_valid and a HOLD-time write to pos.a
        held = mu_flat;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin in_valid = 1'b1; x = W'(0); end
            if (i == 6) in_valid = 1'b0;
            if (i == 10) begin cfg_we = 1'b1; cfg_set = 3'd2; cfg_pt = 2'd0; cfg_data = W'(0); end
            if (i == 11) cfg_we = 1'b0;
            @(negedge clk);
            if (mu_flat !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        check("hold_stable", 64'(bad), 64'd0);
        check("hold_mu", 64'(mu_flat), 64'h0000_5555_2AAA);
        release_out();
        @(negedge clk);
        check("after_hold_in_ready", {63'd0, in_ready}, 64'd1);
        check("after_hold_out_valid", {63'd0, out_valid}, 64'd0);

        // pos is now (0,40,127,127)
        sample("x20_posa", 20, 48'h7FFF_0000_0000);
        release_out();

        // Write to zero.d during EVAL must be dropped
        start_sample(10);
        fork
            wait_result(lat);
            begin
                repeat (3) @(negedge clk);
                cfg_we = 1'b1; cfg_set = 3'd1; cfg_pt = 2'd3; cfg_data = W'(100);
                @(negedge clk);
                cfg_we = 1'b0;
            end
        join
        check("eval_we_lat", 64'(lat), 64'd52);
        check("eval_we_mu", 64'(mu_flat), 64'h3FFF_AAAA_0000);
        release_out();
        sample("eval_we_next", 10, 48'h3FFF_AAAA_0000);
        release_out();

        // Reset in the middle of EVAL
        start_sample(-15);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_mu", 64'(mu_flat), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sample("bank_after_rst", 0, 48'hFFFF_FFFF_FFFF);
        release_out();
        sample("zero_bank_x7", 7, 48'h0000_0000_0000);
        release_out();

        // Unordered zero set (10,5,5,20)
        cfg_write(1, 0, 10); cfg_write(1, 1, 5); cfg_write(1, 2, 5); cfg_write(1, 3, 20);
        sample("order_x7", 7, 48'h0000_0000_0000);
        check("order_err", {63'd0, cfg_err}, {63'd0, exp_err});
        release_out();
        sample("order_x0", 0, 48'hFFFF_0000_FFFF);
        check("order_err_sticky", {63'd0, cfg_err}, {63'd0, exp_err});
        release_out();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
